// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the byte-stream boot loader: FSM state encoding,
// frame constants and checksum width. Imported by program_loader and
// loader_word_assembler.
// -----------------------------------------------------------------------------
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // Frame start byte used when the top-level MAGIC parameter is left alone.
  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // Number of length bytes following MAGIC (LEN_LO, LEN_HI).
  localparam int LEN_BYTES = 2;

  // Width of the wrapping data checksum.
  localparam int CSUM_W = 8;

  // Width of the byte-within-word index (4 bytes per 32-bit word).
  localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/loader_word_assembler.sv
// -----------------------------------------------------------------------------
// loader_word_assembler
// Collects four bytes into a little-endian 32-bit word. Byte k of a word lands
// in bits [8k+7:8k]. The completed word and its strobe are presented
// combinationally on the cycle the fourth byte is shifted in, so the parent can
// register the memory write with a single cycle of latency.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-low
//   clear      restart assembly at byte 0 (frame start)
//   shift_en   byte_in is accepted this cycle
//   byte_in    incoming data byte
//   word       assembled word (valid when word_done = 1)
//   word_done  fourth byte of a word is being accepted this cycle
// -----------------------------------------------------------------------------
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0]           shreg_p0;
  logic [BYTE_IDX_W-1:0] byte_idx_p0;

  // Stage p0: hold bytes 0..2 of the current word, newest at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_p0    <= '0;
      byte_idx_p0 <= '0;
    end else if (clear) begin
      shreg_p0    <= '0;
      byte_idx_p0 <= '0;
    end else if (shift_en) begin
      shreg_p0    <= {byte_in, shreg_p0[23:8]};
      byte_idx_p0 <= byte_idx_p0 + 2'd1;
    end
  end

  // After three shifts shreg_p0 = {b2, b1, b0}; the live byte is b3.
  assign word      = {byte_in, shreg_p0};
  assign word_done = shift_en && (byte_idx_p0 == 2'd3);

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Byte-stream boot loader. Parses frames of the form
//   MAGIC, LEN_LO, LEN_HI, LEN*4 data bytes (little-endian words), CSUM
// and writes each word into instruction memory at BASE_ADDR + 4*index.
// The CPU is held in reset until a frame with a matching checksum completes.
//
// Ports:
//   I_clk           clock, rising edge
//   I_rst           asynchronous reset, active-low
//   I_rx_data       incoming byte
//   I_rx_valid      I_rx_data valid this cycle
//   O_rx_ready      always 1, the loader never back-pressures
//   O_mem_we        one-cycle instruction-memory write strobe
//   O_mem_addr      byte address of the write
//   O_mem_wdata     assembled write word
//   O_cpu_hold      active-high CPU reset request (0 only in DONE)
//   O_done          last frame loaded successfully
//   O_error         last frame failed (bad length, checksum or timeout)
//   O_words_loaded  words written in the current or last frame
// -----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC,
  parameter int          TIMEOUT   = 100000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [7:0]  I_rx_data,
  input  logic        I_rx_valid,
  output logic        O_rx_ready,
  output logic        O_mem_we,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_wdata,
  output logic        O_cpu_hold,
  output logic        O_done,
  output logic        O_error,
  output logic [15:0] O_words_loaded
);

  localparam logic [31:0] MAX_WORDS_U  = MAX_WORDS;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 1;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + b;
  endfunction

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       len_r;
  logic [CSUM_W-1:0] csum;
  logic [31:0]       word_idx;
  logic [31:0]       idle_cnt;

  logic              mem_vld_p1;
  logic [31:0]       mem_addr_p1;
  logic [31:0]       mem_wdata_p1;

  logic              accept;
  logic              frame_start;
  logic              in_frame;
  logic              timed_out;
  logic              asm_shift;
  logic [31:0]       asm_word;
  logic              asm_done;
  logic [15:0]       len_full;
  logic              last_word;

  assign O_rx_ready = 1'b1;
  assign accept     = I_rx_valid;

  assign frame_start = accept && (I_rx_data == MAGIC) &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign in_frame    = (state == ST_LEN0) || (state == ST_LEN1) ||
                       (state == ST_DATA) || (state == ST_CSUM);
  assign timed_out   = in_frame && !accept && (idle_cnt == TIMEOUT_LAST);
  assign asm_shift   = accept && (state == ST_DATA);
  assign len_full    = {I_rx_data, len_lo};
  assign last_word   = (word_idx == ({16'd0, len_r} - 32'd1));

  loader_word_assembler u_asm (
    .clk       (I_clk),
    .rst_n     (I_rst),
    .clear     (frame_start),
    .shift_en  (asm_shift),
    .byte_in   (I_rx_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state          <= ST_IDLE;
      len_lo         <= '0;
      len_r          <= '0;
      csum           <= '0;
      word_idx       <= '0;
      idle_cnt       <= '0;
      mem_vld_p1     <= 1'b0;
      mem_addr_p1    <= BASE_ADDR;
      mem_wdata_p1   <= '0;
      O_words_loaded <= '0;
      O_done         <= 1'b0;
      O_error        <= 1'b0;
      O_cpu_hold     <= 1'b1;
    end else begin
      // Stage p1: memory write issued the cycle after a word's fourth byte.
      mem_vld_p1 <= asm_done;
      if (asm_done) begin
        mem_addr_p1    <= BASE_ADDR + (word_idx << 2);
        mem_wdata_p1   <= asm_word;
        word_idx       <= word_idx + 32'd1;
        O_words_loaded <= O_words_loaded + 16'd1;
      end

      // Idle time is only measured while a frame is in progress.
      if (!in_frame || accept) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end

      if (frame_start) begin
        state          <= ST_LEN0;
        O_done         <= 1'b0;
        O_error        <= 1'b0;
        O_cpu_hold     <= 1'b1;
        csum           <= '0;
        word_idx       <= '0;
        O_words_loaded <= '0;
      end else if (timed_out) begin
        state      <= ST_ERROR;
        O_error    <= 1'b1;
        O_cpu_hold <= 1'b1;
      end else if (accept) begin
        case (state)
          ST_LEN0: begin
            len_lo <= I_rx_data;
            state  <= ST_LEN1;
          end
          ST_LEN1: begin
            len_r <= len_full;
            if ({16'd0, len_full} > MAX_WORDS_U) begin
              state      <= ST_ERROR;
              O_error    <= 1'b1;
              O_cpu_hold <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum <= csum_add(csum, I_rx_data);
            if (asm_done && last_word) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (I_rx_data == csum) begin
              state      <= ST_DONE;
              O_done     <= 1'b1;
              O_cpu_hold <= 1'b0;
            end else begin
              state      <= ST_ERROR;
              O_error    <= 1'b1;
              O_cpu_hold <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign O_mem_we    = mem_vld_p1;
  assign O_mem_addr  = mem_addr_p1;
  assign O_mem_wdata = mem_wdata_p1;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int          TO   = 40;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b0;
  logic [7:0]  I_rx_data = 8'h00;
  logic        I_rx_valid = 1'b0;
  logic        O_rx_ready;
  logic        O_mem_we;
  logic [31:0] O_mem_addr;
  logic [31:0] O_mem_wdata;
  logic        O_cpu_hold;
  logic        O_done;
  logic        O_error;
  logic [15:0] O_words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [63:0] sb[$];   // expected {addr, data} of each memory write
  logic [31:0] fw[$];   // words of the next frame to send

  always #5 I_clk = ~I_clk;

  program_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (1024),
    .MAGIC     (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_rx_data      (I_rx_data),
    .I_rx_valid     (I_rx_valid),
    .O_rx_ready     (O_rx_ready),
    .O_mem_we       (O_mem_we),
    .O_mem_addr     (O_mem_addr),
    .O_mem_wdata    (O_mem_wdata),
    .O_cpu_hold     (O_cpu_hold),
    .O_done         (O_done),
    .O_error        (O_error),
    .O_words_loaded (O_words_loaded)
  );

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge I_clk) begin
    if (I_rst && O_mem_we) begin
      logic [63:0] exp_wr;
      wr_count++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", O_mem_addr, O_mem_wdata);
        n_fail++;
      end else begin
        exp_wr = sb.pop_front();
        if ({O_mem_addr, O_mem_wdata} !== exp_wr) begin
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   O_mem_addr, O_mem_wdata, exp_wr[63:32], exp_wr[31:0]);
          n_fail++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    I_rx_data  = b;
    I_rx_valid = 1'b1;
    @(posedge I_clk);
    #1;
    I_rx_valid = 1'b0;
  endtask

  // Sends a full frame built from fw; the checksum byte is offset by csum_delta.
  // The write strobe must follow each word's fourth byte by exactly one cycle.
  task automatic send_frame(input int len_field, input int csum_delta);
    logic [7:0]  s;
    logic [7:0]  b;
    logic [15:0] lf;
    s  = 8'h00;
    lf = 16'(len_field);
    send_byte(8'hA5);
    send_byte(lf[7:0]);
    send_byte(lf[15:8]);
    for (int i = 0; i < fw.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = fw[i][8*k +: 8];
        s = s + b;
        if (k == 3) sb.push_back({BASE + 32'(i) * 32'd4, fw[i]});
        send_byte(b);
        n_checks++;
        if (O_mem_we !== (k == 3)) begin
          $display("FAIL write_latency: word %0d byte %0d we=%b, expected %b", i, k, O_mem_we, (k == 3));
          n_fail++;
        end
      end
    end
    send_byte(s + 8'(csum_delta));
  endtask

  task automatic test_reset();
    I_rst = 1'b0;
    #12;
    n_checks++;
    if ({O_cpu_hold, O_mem_we, O_done, O_error, O_rx_ready} !== 5'b10001) begin
      $display("FAIL reset_flags: hold/we/done/err/ready=%b%b%b%b%b, expected 10001",
               O_cpu_hold, O_mem_we, O_done, O_error, O_rx_ready);
      n_fail++;
    end
    n_checks++;
    if ({O_mem_addr, O_mem_wdata, O_words_loaded} !== {BASE, 32'h0, 16'h0}) begin
      $display("FAIL reset_data: addr=%h wdata=%h words=%0d, expected %h 0 0",
               O_mem_addr, O_mem_wdata, O_words_loaded, BASE);
      n_fail++;
    end
    @(negedge I_clk);
    I_rst = 1'b1;
    repeat (3) @(posedge I_clk);
    #1;
    n_checks++;
    if ({O_cpu_hold, O_done, O_error} !== 3'b100) begin
      $display("FAIL idle_after_reset: hold/done/err=%b%b%b, expected 100", O_cpu_hold, O_done, O_error);
      n_fail++;
    end
  endtask

  task automatic test_good_frame();
    int w0;
    w0 = wr_count;
    fw = '{32'h0000_0513, 32'h0010_0593};
    send_frame(2, 0);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold} !== 3'b100) begin
      $display("FAIL good_flags: done/err/hold=%b%b%b, expected 100", O_done, O_error, O_cpu_hold);
      n_fail++;
    end
    n_checks++;
    if (O_words_loaded !== 16'd2) begin
      $display("FAIL good_words: got %0d, expected 2", O_words_loaded);
      n_fail++;
    end
    n_checks++;
    if (wr_count - w0 != 2 || sb.size() != 0) begin
      $display("FAIL good_writes: got %0d writes, %0d pending, expected 2 and 0", wr_count - w0, sb.size());
      n_fail++;
    end
  endtask

  task automatic test_bad_csum();
    int w0;
    w0 = wr_count;
    fw = '{32'h0000_0513, 32'h0010_0593};
    send_frame(2, 1);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold} !== 3'b011) begin
      $display("FAIL badcsum_flags: done/err/hold=%b%b%b, expected 011", O_done, O_error, O_cpu_hold);
      n_fail++;
    end
    n_checks++;
    if (wr_count - w0 != 2 || O_words_loaded !== 16'd2) begin
      $display("FAIL badcsum_writes: got %0d writes words=%0d, expected 2 and 2", wr_count - w0, O_words_loaded);
      n_fail++;
    end
    send_byte(8'h00);
    send_byte(8'h13);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold} !== 3'b011) begin
      $display("FAIL error_ignores_bytes: done/err/hold=%b%b%b, expected 011", O_done, O_error, O_cpu_hold);
      n_fail++;
    end
  endtask

  task automatic test_noise_restart();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    fw = '{32'hCAFE_F00D};
    send_frame(1, 0);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold, O_words_loaded} !== {3'b100, 16'd1}) begin
      $display("FAIL restart_after_error: done/err/hold=%b%b%b words=%0d, expected 100 1",
               O_done, O_error, O_cpu_hold, O_words_loaded);
      n_fail++;
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold} !== 3'b011) begin
      $display("FAIL oversize_flags: done/err/hold=%b%b%b, expected 011", O_done, O_error, O_cpu_hold);
      n_fail++;
    end
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    n_checks++;
    if (wr_count != w0 || O_words_loaded !== 16'd0 || O_error !== 1'b1) begin
      $display("FAIL oversize_writes: writes=%0d words=%0d err=%b, expected 0 0 1",
               wr_count - w0, O_words_loaded, O_error);
      n_fail++;
    end
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = wr_count;
    fw.delete();
    send_frame(0, 0);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold} !== 3'b100 || wr_count != w0 || O_words_loaded !== 16'd0) begin
      $display("FAIL zero_len: done/err/hold=%b%b%b writes=%0d words=%0d, expected 100 0 0",
               O_done, O_error, O_cpu_hold, wr_count - w0, O_words_loaded);
      n_fail++;
    end
  endtask

  task automatic test_max_len();
    fw.delete();
    for (int i = 0; i < 1024; i++) fw.push_back((32'(i) * 32'h0101_0101) ^ 32'hDEAD_BEEF);
    send_frame(1024, 0);
    n_checks++;
    if ({O_done, O_error, O_words_loaded} !== {2'b10, 16'd1024} || sb.size() != 0) begin
      $display("FAIL max_len: done/err=%b%b words=%0d pending=%0d, expected 10 1024 0",
               O_done, O_error, O_words_loaded, sb.size());
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wr_count;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TO - 1) @(posedge I_clk);
    #1;
    n_checks++;
    if (O_error !== 1'b0) begin
      $display("FAIL timeout_early: err=%b after %0d idle cycles, expected 0", O_error, TO - 1);
      n_fail++;
    end
    @(posedge I_clk);
    #1;
    n_checks++;
    if ({O_error, O_done, O_cpu_hold} !== 3'b101) begin
      $display("FAIL timeout_flags: err/done/hold=%b%b%b, expected 101", O_error, O_done, O_cpu_hold);
      n_fail++;
    end
    repeat (5) @(posedge I_clk);
    #1;
    n_checks++;
    if (wr_count != w0) begin
      $display("FAIL timeout_writes: got %0d writes, expected 0", wr_count - w0);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_data();
    int w0;
    w0 = wr_count;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    sb.push_back({BASE, 32'h1234_5678});
    send_byte(8'h12);
    send_byte(8'h9A);
    send_byte(8'hBC);
    I_rst = 1'b0;
    #1;
    n_checks++;
    if ({O_cpu_hold, O_mem_we, O_done, O_error} !== 4'b1000 ||
        {O_mem_addr, O_mem_wdata, O_words_loaded} !== {BASE, 32'h0, 16'h0}) begin
      $display("FAIL midreset_outputs: hold/we/done/err=%b%b%b%b addr=%h wdata=%h words=%0d, expected 1000 %h 0 0",
               O_cpu_hold, O_mem_we, O_done, O_error, O_mem_addr, O_mem_wdata, O_words_loaded, BASE);
      n_fail++;
    end
    n_checks++;
    if (wr_count - w0 != 1 || sb.size() != 0) begin
      $display("FAIL midreset_writes: got %0d writes %0d pending, expected 1 and 0", wr_count - w0, sb.size());
      n_fail++;
    end
    @(negedge I_clk);
    I_rst = 1'b1;
    @(posedge I_clk);
    #1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    fw = '{32'h0000_0513, 32'h0010_0593};
    send_frame(2, 0);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold, O_words_loaded} !== {3'b100, 16'd2}) begin
      $display("FAIL midreset_recover: done/err/hold=%b%b%b words=%0d, expected 100 2",
               O_done, O_error, O_cpu_hold, O_words_loaded);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hA5);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold, O_words_loaded} !== {3'b001, 16'd0}) begin
      $display("FAIL len0_entry: done/err/hold=%b%b%b words=%0d, expected 001 0",
               O_done, O_error, O_cpu_hold, O_words_loaded);
      n_fail++;
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    fw = '{32'h1111_2222, 32'h8000_00FF, 32'hFFFF_FFFF};
    send_frame(3, 0);
    n_checks++;
    if ({O_done, O_error, O_cpu_hold, O_words_loaded} !== {3'b100, 16'd3} || sb.size() != 0) begin
      $display("FAIL back_to_back: done/err/hold=%b%b%b words=%0d pending=%0d, expected 100 3 0",
               O_done, O_error, O_cpu_hold, O_words_loaded, sb.size());
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_noise_restart();
    test_oversize();
    test_zero_len();
    test_max_len();
    test_timeout();
    test_reset_mid_data();
    test_back_to_back();
    repeat (3) @(posedge I_clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL final_scoreboard: %0d writes outstanding, expected 0", sb.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
